// File: rtl/gray_input_capture.sv
// gray_input_capture
// Front end of the Gray-to-binary converter: synchronises the raw switch
// word, debounces it, and publishes one stable registered Gray word with a
// single-cycle update strobe. Committed transitions that flip more than one
// bit raise a sticky step error (the first commit after reset is exempt).
// WIDTH must be at least 2 and DEBOUNCE_CYCLES at least 1.

module gray_input_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] gray_out,
  output logic             gray_valid,
  output logic             step_err
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE,    // cand matches the committed word
    ST_SETTLING   // cand differs and is being qualified
  } state_e;

  logic [WIDTH-1:0] sync1_q, sync_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_out_q, gray_out_d;
  logic             gray_valid_q, gray_valid_d;
  logic             step_err_q, step_err_d;
  logic             first_done_q, first_done_d;
  state_e           state_q, state_d;

  // Number of bits that differ between two words.
  function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // Two-flop synchroniser; only sync_q is consumed downstream.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  // NOTE: reset is asynchronous (in the sensitivity list) so outputs clear
  // immediately, without needing a running clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= sw_gray_in;
      sync_q  <= sync1_q;
    end
  end

  // Next-state logic: input change restarts qualification, otherwise count
  // in SETTLING and commit once the value has persisted long enough.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    gray_out_d   = gray_out_q;
    gray_valid_d = 1'b0;
    step_err_d   = err_clr ? 1'b0 : step_err_q;
    first_done_d = first_done_q;
    state_d      = state_q;

    if (sync_q != cand_q) begin
      cand_d  = sync_q;
      cnt_d   = '0;
      state_d = (sync_q == gray_out_q) ? ST_STABLE : ST_SETTLING;
    end else if (state_q == ST_STABLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      gray_out_d   = cand_q;
      gray_valid_d = 1'b1;
      cnt_d        = '0;
      state_d      = ST_STABLE;
      first_done_d = 1'b1;
      // Setting wins over a simultaneous err_clr.
      if (first_done_q && (popcount(cand_q ^ gray_out_q) > 1)) begin
        step_err_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state machine and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q       <= '0;
      cnt_q        <= '0;
      gray_out_q   <= '0;
      gray_valid_q <= 1'b0;
      step_err_q   <= 1'b0;
      first_done_q <= 1'b0;
      state_q      <= ST_STABLE;
    end else begin
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      gray_out_q   <= gray_out_d;
      gray_valid_q <= gray_valid_d;
      step_err_q   <= step_err_d;
      first_done_q <= first_done_d;
      state_q      <= state_d;
    end
  end

  assign gray_out   = gray_out_q;
  assign gray_valid = gray_valid_q;
  assign step_err   = step_err_q;

endmodule

// File: tb/tb_gray_input_capture.sv
// Testbench for gray_input_capture (WIDTH = 4, DEBOUNCE_CYCLES = 4).
// Directed scenarios followed by random holds; every edge is compared with a
// behavioural model built on the rule "a value seen at the synchroniser
// output for DEBOUNCE_CYCLES+1 consecutive edges, and different from the
// committed word, is committed on the last of those edges".

module tb_gray_input_capture;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         err_clr;
  logic [W-1:0] sw_gray_in;
  logic [W-1:0] gray_out;
  logic         gray_valid;
  logic         step_err;

  int n_assert   = 0;
  int n_fail     = 0;
  int valid_seen = 0;

  // Reference model state.
  logic [W-1:0] hist[$];   // most recent input samples, newest last
  logic [W-1:0] m_last;    // value currently seen at the synchroniser output
  int           m_run;     // consecutive edges m_last has been seen
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_err;
  logic         m_first;

  gray_input_capture #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_gray_in(sw_gray_in),
    .err_clr   (err_clr),
    .gray_out  (gray_out),
    .gray_valid(gray_valid),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_last  = '0;
    m_run   = 0;
    m_out   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_first = 1'b0;
  endtask

  // Advance the model by one rising edge that sampled input x.
  task automatic model_edge(input logic [W-1:0] x, input logic clr);
    logic [W-1:0] v;
    logic         commit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(x);
    if (hist.size() > 3) void'(hist.pop_front());
    // The synchroniser output before this edge is the sample from two edges ago.
    v = (hist.size() == 3) ? hist[0] : '0;
    m_run  = (v == m_last) ? m_run + 1 : 1;
    m_last = v;
    commit = (m_run >= D + 1) && (v != m_out);
    if (clr) m_err = 1'b0;
    if (commit) begin
      if (m_first && ($countones(v ^ m_out) > 1)) m_err = 1'b1;
      m_first = 1'b1;
      m_out   = v;
    end
    m_valid = commit;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":gray_out"},   32'(gray_out),   32'(m_out));
    check({tag, ":gray_valid"}, 32'(gray_valid), 32'(m_valid));
    check({tag, ":step_err"},   32'(step_err),   32'(m_err));
  endtask

  // Drive one input value across one rising edge and compare against the model.
  task automatic tick(input logic [W-1:0] val, input logic clr, input string tag);
    sw_gray_in = val;
    err_clr    = clr;
    @(posedge clk);
    model_edge(val, clr);
    #1;
    check_outputs(tag);
    if (gray_valid === 1'b1) valid_seen++;
    err_clr = 1'b0;
  endtask

  task automatic hold(input logic [W-1:0] val, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(val, 1'b0, tag);
  endtask

  initial begin
    logic [W-1:0] rv;
    int           rn;

    // 1. Reset with a nonzero input; first commit is exempt from the step check.
    rst_n      = 1'b0;
    err_clr    = 1'b0;
    sw_gray_in = 4'b0110;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst:gray_out",   32'(gray_out),   32'h0);
    check("rst:gray_valid", 32'(gray_valid), 32'h0);
    check("rst:step_err",   32'(step_err),   32'h0);
    #3 rst_n = 1'b1;
    valid_seen = 0;
    hold(4'b0110, 8, "s1");
    check("s1:final_out", 32'(gray_out),  32'h6);
    check("s1:pulses",    32'(valid_seen), 32'd1);

    // 2. Legal single-bit step.
    valid_seen = 0;
    hold(4'b0111, 8, "s2");
    check("s2:pulses", 32'(valid_seen), 32'd1);
    check("s2:err",    32'(step_err),   32'h0);

    // 3. Glitch too short is rejected; minimum persistence commits.
    valid_seen = 0;
    hold(4'b0101, 3, "s3_glitch");
    hold(4'b0111, 6, "s3_back");
    check("s3:no_pulse", 32'(valid_seen), 32'd0);
    check("s3:held_out", 32'(gray_out),   32'h7);
    hold(4'b0101, 5, "s3_min");
    hold(4'b0111, 2, "s3_min_back");
    check("s3:min_commit", 32'(gray_out), 32'h5);
    hold(4'b0101, 8, "s3_return");

    // 4. Illegal step, sticky flag, clear, and set-wins-over-clear.
    hold(4'b0110, 8, "s4_bad");
    check("s4:err_set", 32'(step_err), 32'h1);
    hold(4'b0111, 8, "s4_legal");
    check("s4:err_sticky", 32'(step_err), 32'h1);
    tick(4'b0111, 1'b1, "s4_clr");
    check("s4:err_cleared", 32'(step_err), 32'h0);
    hold(4'b0111, 2, "s4_idle");
    hold(4'b0100, 6, "s4_bad2");
    tick(4'b0100, 1'b1, "s4_clr_commit");
    check("s4:set_wins", 32'(step_err), 32'h1);
    hold(4'b0100, 2, "s4_after");
    hold(4'b0101, 8, "s4_prep");

    // 5. Bounce, then settle.
    valid_seen = 0;
    for (int i = 0; i < 5; i++) begin
      hold(4'b0100, 2, "s5_bounce");
      hold(4'b0101, 2, "s5_bounce");
    end
    check("s5:bounce_quiet", 32'(valid_seen), 32'd0);
    hold(4'b0100, 10, "s5_settle");
    check("s5:one_pulse", 32'(valid_seen), 32'd1);
    check("s5:out",       32'(gray_out),   32'h4);

    // 6. Reset during settling, then requalify from scratch.
    hold(4'b1100, 4, "s6_pre");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("s6_async");
    hold(4'b1100, 2, "s6_inrst");
    #4 rst_n = 1'b1;
    valid_seen = 0;
    hold(4'b1100, 8, "s6_post");
    check("s6:out",    32'(gray_out),   32'hC);
    check("s6:pulses", 32'(valid_seen), 32'd1);
    check("s6:err",    32'(step_err),   32'h0);

    // Random holds of random length with occasional error clears.
    for (int i = 0; i < 250; i++) begin
      rv = W'($urandom_range(0, 15));
      rn = $urandom_range(1, 7);
      for (int j = 0; j < rn; j++) begin
        tick(rv, ($urandom_range(0, 7) == 0), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_input_capture.md
# gray_input_capture

Upstream stage of the Gray-to-binary converter. Samples the asynchronous Gray-coded switch inputs, synchronises them to the system clock, and debounces them. It presents one stable registered Gray word to the converter with a one-cycle update strobe. It also flags any committed transition that changes more than one bit, which is an illegal Gray step.

## Interface

Parameters:
- WIDTH, 4, Gray word width; must be at least 2.
- DEBOUNCE_CYCLES, 250000, consecutive cycles a new value must persist before it is committed; must be at least 1.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_gray_in  input  WIDTH  raw Gray word from the switches; asynchronous, may bounce.
- err_clr  input  1  synchronous clear for step_err.
- gray_out  output  WIDTH  last committed stable Gray word; registered; feeds the converter's gray_in.
- gray_valid  output  1  high for exactly one cycle after each edge where gray_out is written.
- step_err  output  1  sticky flag: a committed transition changed more than one bit.

## Operation

- **Synchroniser.** Two-flop chain per bit: sw_gray_in → sync1 → sync_q. Only sync_q is used downstream.
- **Candidate register.** cand holds the value being qualified. cnt counts qualification cycles and is wide enough to hold DEBOUNCE_CYCLES-1.
- **State machine.** Two states:
  - STABLE: cand == gray_out.
  - SETTLING: cand != gray_out.
- **Per-edge priority, first match wins:**
  1. If sync_q != cand: cand ← sync_q, cnt ← 0. The next state follows from the new cand.
  2. Else if STABLE: cnt ← 0. Nothing else changes.
  3. Else (SETTLING, sync_q == cand):
     - If cnt == DEBOUNCE_CYCLES-1: commit (gray_out ← cand, gray_valid ← 1, cnt ← 0) and go to STABLE.
     - Otherwise cnt ← cnt+1.
- **gray_valid** is 0 on every edge that does not commit.
- **Returning glitch.** If the input returns to the committed value during SETTLING, rule 1 loads cand with it and the state becomes STABLE. No commit and no strobe occur.
- **Step check.** On a commit, compute popcount(cand ^ gray_out) against the old gray_out. If it is greater than 1, set step_err.
  - The first commit after reset is exempt (first_done flag, set by the first commit).
- **err_clr.** Clears step_err on the next edge. If an erroneous commit happens on the same edge, the set wins and step_err = 1.
- **Reset values.** sync1, sync_q, cand, gray_out = 0; cnt = 0; gray_valid = 0; step_err = 0; first_done = 0; state = STABLE.
- **Reset mid-operation.**
  - An in-progress qualification is abandoned.
  - After release, a nonzero input is requalified from scratch with the full latency.
  - The commit that follows is the exempt first commit.

## Timing

- Let E0 be the first rising edge that samples a new stable input value into sync1.
  - E1: sync_q takes the new value.
  - E2: cand takes the new value.
  - E(2+DEBOUNCE_CYCLES): gray_out updates and gray_valid rises; gray_valid falls at the following edge.
- **Latency** from E0 to commit: 2+DEBOUNCE_CYCLES edges.
- **Minimum accepted persistence:** the input must be sampled unchanged at DEBOUNCE_CYCLES+1 consecutive edges (E0 through E(DEBOUNCE_CYCLES)). A shorter value is never committed.
- **Bounce.** Any change seen at sync_q restarts qualification. A bouncing input produces no strobe until it settles.
- **Strobe spacing.** Consecutive gray_valid pulses are at least DEBOUNCE_CYCLES+1 cycles apart.
- **Output stability.** gray_out never changes except on a commit edge, so the downstream converter sees a glitch-free word.
- **Reset.** Assertion takes effect immediately, without waiting for a clock edge. Release is synchronous to clk by system convention.

## Test plan

All scenarios run with DEBOUNCE_CYCLES = 4 and WIDTH = 4.

1. **Reset and exempt first commit.** Hold rst_n low with sw_gray_in = 0110.
   - While in reset: gray_out = 0000, gray_valid = 0, step_err = 0.
   - Release rst_n and hold 0110: gray_out = 0110 with one gray_valid pulse at E6; step_err stays 0.
2. **Legal single-bit step.** From committed 0110, change to 0111 and hold.
   - Commit at E6: exactly one gray_valid cycle, step_err = 0.
   - gray_out does not change at E0 through E5.
3. **Glitch rejection.**
   - From 0111, drive 0101 for 3 edges, then return to 0111: no gray_valid, gray_out = 0111.
   - Driving 0101 for 5 edges instead commits it.
4. **Illegal step and clear.**
   - From 0101, jump to 0110 (two bits): commit at E6 and step_err = 1; it remains 1 across further legal commits.
   - Pulse err_clr: step_err = 0 next cycle.
   - Assert err_clr on the same edge as another two-bit commit: step_err = 1.
5. **Bounce.** Alternate 0100/0101 every 2 cycles for 20 cycles, then hold 0100.
   - No gray_valid during the bounce.
   - Exactly one gray_valid, 6 edges after 0100 is first sampled for the final time.
6. **Reset mid-settling.** Drive a new value and assert rst_n at E3.
   - All outputs return to 0 immediately.
   - After release with the value still held: commit 6 edges after the first post-reset sampling edge, step_err = 0.
